// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Pipelined approximate unsigned multiplier. Operands are split into high
//   and low halves. The four half-width partial products can each be truncated
//   (low TRUNC bits cleared), selected per quadrant by a run-time mode register.
//   The aligned products are combined by a lower-part-OR adder: the low LOA
//   result bits are a plain OR and no carry leaves them.
//   Three registered stages: S1 holds operands and mode, S2 holds the masked
//   partial products, S3 holds the result. A single stall signal freezes all
//   stages while the output is held.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   cfg_we     load the mode register from cfg_mode
//   cfg_mode   per-quadrant truncate enable: [0]=LL [1]=LH [2]=HL [3]=HH
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (not stalled)
//   a, b       unsigned operands, WIDTH bits
//   out_valid  result valid
//   out_ready  downstream accepts result
//   r          approximate product, 2*WIDTH bits
//   r_mode     mode register value captured with this transaction
module approx_mult_pipe #(
  parameter int         WIDTH    = 8,
  parameter int         TRUNC    = 2,
  parameter int         LOA      = 6,
  parameter logic [3:0] MODE_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r,
  output logic [3:0]           r_mode
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  // Mask that clears the low TRUNC bits of a partial product.
  localparam logic [WIDTH-1:0] TMASK = (TRUNC >= WIDTH) ? '0 : ({WIDTH{1'b1}} << TRUNC);
  // Mask selecting the OR-only low part of the result.
  localparam logic [W2-1:0]    LMASK = ~({W2{1'b1}} << LOA);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [3:0] mode_reg;

  // S1
  logic             v1;
  logic [WIDTH-1:0] a1, b1;
  logic [3:0]       m1;

  // S2
  logic             v2;
  logic [WIDTH-1:0] ll2, lh2, hl2, hh2;
  logic [3:0]       m2;

  function automatic logic [WIDTH-1:0] pp_mul(input logic [H-1:0] x,
                                              input logic [H-1:0] y,
                                              input logic         trunc);
    logic [WIDTH-1:0] p;
    p = {{H{1'b0}}, x} * {{H{1'b0}}, y};
    return trunc ? (p & TMASK) : p;
  endfunction

  logic [WIDTH-1:0] ll_c, lh_c, hl_c, hh_c;

  always_comb begin
    ll_c = pp_mul(a1[H-1:0],     b1[H-1:0],     m1[0]);
    lh_c = pp_mul(a1[H-1:0],     b1[WIDTH-1:H], m1[1]);
    hl_c = pp_mul(a1[WIDTH-1:H], b1[H-1:0],     m1[2]);
    hh_c = pp_mul(a1[WIDTH-1:H], b1[WIDTH-1:H], m1[3]);
  end

  logic [W2-1:0] t0, t1, t2, t3, hi_sum, r_c;

  // The high sum is formed on pre-shifted terms so carries out of the low
  // LOA bits can never reach it; shifting back truncates to 2*WIDTH bits.
  always_comb begin
    t0     = {{WIDTH{1'b0}}, ll2};
    t1     = {{H{1'b0}}, lh2, {H{1'b0}}};
    t2     = {{H{1'b0}}, hl2, {H{1'b0}}};
    t3     = {hh2, {WIDTH{1'b0}}};
    hi_sum = (t0 >> LOA) + (t1 >> LOA) + (t2 >> LOA) + (t3 >> LOA);
    r_c    = (hi_sum << LOA) | ((t0 | t1 | t2 | t3) & LMASK);
  end

  // Mode register updates independently of the pipe. A transaction accepted
  // on the same edge samples the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg <= MODE_RST;
    end else if (cfg_we) begin
      mode_reg <= cfg_mode;
    end
  end

  // Bubbles advance like valid slots, so data registers load whenever the
  // pipe moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      m1        <= '0;
      v2        <= 1'b0;
      ll2       <= '0;
      lh2       <= '0;
      hl2       <= '0;
      hh2       <= '0;
      m2        <= '0;
      out_valid <= 1'b0;
      r         <= '0;
      r_mode    <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      a1        <= a;
      b1        <= b;
      m1        <= mode_reg;
      v2        <= v1;
      ll2       <= ll_c;
      lh2       <= lh_c;
      hl2       <= hl_c;
      hh2       <= hh_c;
      m2        <= m1;
      out_valid <= v2;
      r         <= r_c;
      r_mode    <= m2;
    end
  end

endmodule
